// File: rtl/alu_arbiter_if.sv
// Handshake bundle between two ALU requesters, the arbiter and the result consumer.
// The master side drives requests and consumes results; the slave side is the arbiter.
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [2:0]  req0_f;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [2:0]  req1_f;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_y;
  logic        rsp_zero;
  logic        rsp_id;

  modport master (
    output req0_valid, req0_a, req0_b, req0_f,
    output req1_valid, req1_a, req1_b, req1_f,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_y, rsp_zero, rsp_id
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_f,
    input  req1_valid, req1_a, req1_b, req1_f,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_y, rsp_zero, rsp_id
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter sharing one 32-bit ALU with a single-entry result register.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 always wins contention).
module alu_arbiter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  alu_arbiter_if.slave     bus,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] f);
    logic [31:0] y;
    case (f)
      3'b000, 3'b100: y = a & b;
      3'b001, 3'b101: y = a | b;
      3'b010:         y = a + b;
      3'b110:         y = a - b;
      3'b111:         y = {31'd0, (a < b)};
      default:        y = 32'd0;
    endcase
    return y;
  endfunction

  logic             rsp_valid_q;
  logic [31:0]      rsp_y_q;
  logic             rsp_zero_q;
  logic             rsp_id_q;
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;

  logic        out_free;
  logic        pick1;
  logic        gnt0;
  logic        gnt1;
  logic [31:0] alu_y;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign pick1 = !bus.req0_valid;
`else
  logic rr_q;
  // rr_q names the requester favoured when both are valid.
  assign pick1 = bus.req1_valid && (!bus.req0_valid || rr_q);
`endif

  assign out_free = !rsp_valid_q || bus.rsp_ready;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset && out_free) begin
      gnt0 = bus.req0_valid && !pick1;
      gnt1 = bus.req1_valid && pick1;
    end
  end

  always_comb begin
    alu_y = 32'd0;
    if (gnt1) alu_y = alu(bus.req1_a, bus.req1_b, bus.req1_f);
    else      alu_y = alu(bus.req0_a, bus.req0_b, bus.req0_f);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_y_q     <= 32'd0;
      rsp_zero_q  <= 1'b1;
      rsp_id_q    <= 1'b0;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
    end else begin
      if (gnt0 || gnt1) begin
        rsp_valid_q <= 1'b1;
        rsp_y_q     <= alu_y;
        rsp_zero_q  <= (alu_y == 32'd0);
        rsp_id_q    <= gnt1;
      end else if (bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
      if (gnt0) cnt0_q <= cnt0_q + CNT_W'(1);
      if (gnt1) cnt1_q <= cnt1_q + CNT_W'(1);
    end
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q <= 1'b0;
    end else if (gnt0) begin
      rr_q <= 1'b1;
    end else if (gnt1) begin
      rr_q <= 1'b0;
    end
  end
`endif

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_y      = rsp_y_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.rsp_id     = rsp_id_q;
  assign grant_cnt0     = cnt0_q;
  assign grant_cnt1     = cnt1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter: functions, arbitration, back-pressure,
// mid-operation reset and counter wrap (second instance with 4-bit counters).
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  logic [15:0] cnt0;
  logic [15:0] cnt1;
  logic [3:0]  w_cnt0;
  logic [3:0]  w_cnt1;

  alu_arbiter_if bus ();
  alu_arbiter_if wbus ();

  alu_arbiter #(.CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .grant_cnt0 (cnt0),
    .grant_cnt1 (cnt1)
  );

  alu_arbiter #(.CNT_W(4)) dut_wrap (
    .clk        (clk),
    .reset      (reset),
    .bus        (wbus),
    .grant_cnt0 (w_cnt0),
    .grant_cnt1 (w_cnt1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op on requester 1 with the result register free, then check the result.
  task automatic issue1(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] f, input logic [31:0] exp_y, input logic exp_z);
    bus.req1_valid = 1'b1;
    bus.req1_a = a;
    bus.req1_b = b;
    bus.req1_f = f;
    #1;
    check({tag, "_ready"}, 32'(bus.req1_ready), 32'd1);
    tick();
    bus.req1_valid = 1'b0;
    check({tag, "_y"}, bus.rsp_y, exp_y);
    check({tag, "_zero"}, 32'(bus.rsp_zero), 32'(exp_z));
    check({tag, "_id"}, 32'(bus.rsp_id), 32'd1);
  endtask

  logic [31:0] held_y;

  initial begin
    bus.req0_valid = 1'b1;
    bus.req0_a = 32'd0; bus.req0_b = 32'd0; bus.req0_f = 3'd0;
    bus.req1_valid = 1'b1;
    bus.req1_a = 32'd0; bus.req1_b = 32'd0; bus.req1_f = 3'd0;
    bus.rsp_ready = 1'b1;
    wbus.req0_valid = 1'b0;
    wbus.req0_a = 32'd0; wbus.req0_b = 32'd0; wbus.req0_f = 3'd0;
    wbus.req1_valid = 1'b0;
    wbus.req1_a = 32'd0; wbus.req1_b = 32'd0; wbus.req1_f = 3'd0;
    wbus.rsp_ready = 1'b1;

    // Requests during reset must not be accepted.
    #1;
    check("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
    check("rst_req1_ready", 32'(bus.req1_ready), 32'd0);
    tick();
    tick();
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_y", bus.rsp_y, 32'd0);
    check("rst_rsp_zero", 32'(bus.rsp_zero), 32'd1);
    check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("rst_cnt0", 32'(cnt0), 32'd0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    reset = 1'b0;

    // Single request on requester 0: 5 + 3.
    bus.req0_valid = 1'b1;
    bus.req0_a = 32'd5; bus.req0_b = 32'd3; bus.req0_f = 3'b010;
    #1;
    check("single_req0_ready", 32'(bus.req0_ready), 32'd1);
    tick();
    bus.req0_valid = 1'b0;
    check("single_valid", 32'(bus.rsp_valid), 32'd1);
    check("single_y", bus.rsp_y, 32'd8);
    check("single_zero", 32'(bus.rsp_zero), 32'd0);
    check("single_id", 32'(bus.rsp_id), 32'd0);
    check("single_cnt0", 32'(cnt0), 32'd1);

    // Function sweep on requester 1.
    issue1("sub", 32'd3, 32'd3, 3'b110, 32'd0, 1'b1);
    issue1("slt", 32'd1, 32'hFFFF_FFFF, 3'b111, 32'd1, 1'b0);
    issue1("add_wrap", 32'hFFFF_FFFF, 32'd1, 3'b010, 32'd0, 1'b1);
    issue1("rsvd", 32'h1234_5678, 32'h1111_1111, 3'b011, 32'd0, 1'b1);
    issue1("and4", 32'h0000_F0F0, 32'h0000_FF00, 3'b100, 32'h0000_F000, 1'b0);
    issue1("or1", 32'h0000_F0F0, 32'h0000_FF00, 3'b001, 32'h0000_FFF0, 1'b0);
    issue1("sub_neg", 32'd2, 32'd5, 3'b110, 32'hFFFF_FFFD, 1'b0);
    check("sweep_cnt1", 32'(cnt1), 32'd7);

    // Drain without a new grant keeps the data fields.
    tick();
    check("drain_valid", 32'(bus.rsp_valid), 32'd0);
    check("drain_y_kept", bus.rsp_y, 32'hFFFF_FFFD);

    // Hold a result under back-pressure, then reset mid-operation.
    bus.rsp_ready = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_a = 32'd9; bus.req0_b = 32'd6; bus.req0_f = 3'b001;
    tick();
    bus.req0_valid = 1'b0;
    check("pre_rst_valid", 32'(bus.rsp_valid), 32'd1);
    check("pre_rst_y", bus.rsp_y, 32'd15);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_valid", 32'(bus.rsp_valid), 32'd0);
    check("midrst_y", bus.rsp_y, 32'd0);
    check("midrst_zero", 32'(bus.rsp_zero), 32'd1);
    check("midrst_cnt0", 32'(cnt0), 32'd0);
    check("midrst_cnt1", 32'(cnt1), 32'd0);

    // Contention: both valid for 6 cycles, first grant must go to requester 0.
    bus.rsp_ready = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_a = 32'd10; bus.req0_b = 32'd1; bus.req0_f = 3'b010;
    bus.req1_valid = 1'b1;
    bus.req1_a = 32'd20; bus.req1_b = 32'd1; bus.req1_f = 3'b010;
    for (int i = 0; i < 6; i++) begin
      tick();
`ifdef ALU_ARB_FIXED_PRIO_EN
      check($sformatf("cont_id%0d", i), 32'(bus.rsp_id), 32'd0);
      check($sformatf("cont_y%0d", i), bus.rsp_y, 32'd11);
`else
      check($sformatf("cont_id%0d", i), 32'(bus.rsp_id), 32'(i % 2));
      check($sformatf("cont_y%0d", i), bus.rsp_y, (i % 2 == 0) ? 32'd11 : 32'd21);
`endif
    end
    bus.req0_valid = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    check("cont_cnt0", 32'(cnt0), 32'd6);
    check("cont_cnt1", 32'(cnt1), 32'd0);
    held_y = 32'd11;
`else
    check("cont_cnt0", 32'(cnt0), 32'd3);
    check("cont_cnt1", 32'(cnt1), 32'd3);
    held_y = 32'd21;
`endif

    // Back-pressure: held result blocks requester 1 for 4 cycles.
    bus.rsp_ready = 1'b0;
    bus.req1_a = 32'd7; bus.req1_b = 32'd2; bus.req1_f = 3'b110;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("bp_ready%0d", i), 32'(bus.req1_ready), 32'd0);
      check($sformatf("bp_valid%0d", i), 32'(bus.rsp_valid), 32'd1);
      check($sformatf("bp_y%0d", i), bus.rsp_y, held_y);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(bus.req1_ready), 32'd1);
    tick();
    bus.req1_valid = 1'b0;
    check("bp_new_y", bus.rsp_y, 32'd5);
    check("bp_new_id", 32'(bus.rsp_id), 32'd1);
    check("bp_new_valid", 32'(bus.rsp_valid), 32'd1);

    // Counter wrap on the 4-bit instance.
    wbus.req0_valid = 1'b1;
    wbus.req0_a = 32'd1; wbus.req0_b = 32'd1; wbus.req0_f = 3'b010;
    for (int i = 0; i < 15; i++) tick();
    check("wrap_cnt_15", 32'(w_cnt0), 32'd15);
    tick();
    tick();
    wbus.req0_valid = 1'b0;
    check("wrap_cnt_17", 32'(w_cnt0), 32'd1);
    check("wrap_y", wbus.rsp_y, 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one 32-bit ALU datapath between two independent requesters with valid/ready handshakes. Each cycle it grants at most one requester round-robin, evaluates that requester's operation, and holds the result in a single-entry output register tagged with the winner's ID. It sits between the two issue ports and the writeback/consumer stage. It also keeps per-requester grant counters for performance observation.

## Interface
- `CNT_W`, 16, width of each grant counter
- `clk`  input  1  rising-edge clock
- `reset`  input  1  synchronous, active-high reset
- `req0_valid`  input  1  requester 0 has an operation
- `req0_ready`  output  1  requester 0 operation accepted this cycle
- `req0_a`, `req0_b`  input  32  requester 0 operands
- `req0_f`  input  3  requester 0 ALU function
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_f`: same as requester 0, for requester 1
- `rsp_valid`  output  1  result register holds a result
- `rsp_ready`  input  1  consumer takes result this cycle
- `rsp_y`  output  32  result
- `rsp_zero`  output  1  high when `rsp_y` == 0
- `rsp_id`  output  1  requester that issued the result
- `grant_cnt0`, `grant_cnt1`  output  CNT_W  accepted-operation counts

## Operation
- Function encoding (f):
  - 000 and 100: a & b
  - 001 and 101: a | b
  - 010: a + b, modulo 2^32, carry discarded
  - 110: a − b, modulo 2^32
  - 111: unsigned a < b, giving 32'd1 or 32'd0
  - 011: reserved; y = 0 and zero = 1
- Output register is free when `!rsp_valid || rsp_ready`.
- No grant is issued when the output register is not free. Both `reqN_ready` are then 0.
- When the register is free and exactly one requester is valid, that requester is granted.
- When the register is free and both are valid, the requester selected by round-robin pointer `rr` is granted.
- `reqN_ready` = grant to N. It is combinational from valids, `rsp_valid`, `rsp_ready` and `rr`. At most one `ready` is high per cycle.
- `reqN_ready` never depends on `reqN_valid` being low. A requester that is not valid is never granted.
- On a grant (handshake on requester N):
  - the ALU result, zero flag and N load into `rsp_*`
  - `rsp_valid` goes to 1
  - `rr` becomes !N
  - `grant_cntN` increments, wrapping modulo 2^CNT_W
- Drain without a new grant: `rsp_valid` goes to 0. `rsp_y`, `rsp_zero` and `rsp_id` keep their last values.
- Drain and grant in the same cycle: the new result replaces the old one and `rsp_valid` stays 1.
- `rsp_*` stays stable while `rsp_valid && !rsp_ready`.
- Reset values:
  - `rsp_valid` = 0, `rsp_y` = 0, `rsp_zero` = 1, `rsp_id` = 0
  - `rr` = 0 (requester 0 favoured)
  - both counters = 0
  - both `reqN_ready` = 0 during reset
- Reset asserted mid-transaction drops any held result without delivering it. Requests presented during reset are not accepted.

## Timing
- Latency: an operation accepted at edge N shows on `rsp_*` with `rsp_valid` = 1 after edge N.
- Throughput: one operation per cycle while `rsp_ready` is held high.
- Alternation under contention: with both requesters continuously valid and `rsp_ready` high, grants alternate 0,1,0,1… starting with 0 after reset.
- Back-pressure: while `rsp_ready` is low and `rsp_valid` is high, no requester is accepted. Grants resume in the cycle `rsp_ready` rises, so there is no bubble.
- Requesters must hold a, b and f stable while valid and not ready. The arbiter samples them only on the handshake cycle.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN` defined: fixed priority. Requester 0 always wins contention, and `rr` is not implemented (or is ignored).
- `ALU_ARB_FIXED_PRIO_EN` undefined: round-robin as specified above.
- All other behaviour is identical in both builds.

## Test plan
- Reset then single request:
  - stimulus: req0 a=5, b=3, f=010, `rsp_ready`=1
  - required: `req0_ready`=1 that cycle; next cycle `rsp_valid`=1, `rsp_y`=8, `rsp_zero`=0, `rsp_id`=0, `grant_cnt0`=1
- Function sweep on req1:
  - SUB: a=3, b=3, f=110 → y=0, zero=1
  - SLT: a=1, b=0xFFFFFFFF, f=111 → y=1
  - ADD: a=0xFFFFFFFF, b=1, f=010 → y=0, zero=1
  - reserved: f=011 → y=0, zero=1
- Contention:
  - stimulus: both valid for 6 cycles, `rsp_ready`=1
  - required: `rsp_id` sequence 0,1,0,1,0,1; counters 3/3. With `ALU_ARB_FIXED_PRIO_EN`: sequence all 0
- Back-pressure:
  - stimulus: result held with `rsp_ready`=0 for 4 cycles, req1 valid
  - required: `req1_ready`=0 and `rsp_*` unchanged throughout; when `rsp_ready`=1, `req1_ready`=1 in that same cycle and the new result appears the next cycle
- Reset mid-operation:
  - stimulus: assert reset while `rsp_valid`=1
  - required: next cycle `rsp_valid`=0, `rsp_y`=0, `rsp_zero`=1, counters 0, `rr` favours requester 0
- Counter wrap:
  - stimulus: CNT_W=4, 17 req0 grants
  - required: `grant_cnt0`=1
